// File: rtl/tomasulo_defs.sv
// Shared Tomasulo definitions: station tags, add/sub opcodes, station FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tomasulo_defs;

    // Station tags; tag 0 means "value already present in V"
    localparam logic [2:0] FREE_REGISTER      = 3'd0;
    localparam logic [2:0] RES_STATION_ADD1   = 3'd1;
    localparam logic [2:0] RES_STATION_ADD2   = 3'd2;
    localparam logic [2:0] RES_STATION_LOAD1  = 3'd3;
    localparam logic [2:0] RES_STATION_LOAD2  = 3'd4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OPS = 2'd1,
        ST_EXEC     = 2'd2,
        ST_WRITE    = 2'd3
    } rs_state_t;

endpackage

// File: rtl/add_reservation_station_exec.sv
// Latency counter plus registered 16-bit add/sub (modulo 2^16).
// Latency: result registered LATENCY cycles after the start edge.
// Backpressure: none; done is a strobe for the final counting cycle, result holds until the next run.
module add_sub_exec
    import tomasulo_defs::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [15:0] result
);

    logic        running;
    logic [3:0]  cnt;
    logic        op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;

    // High in the cycle whose closing edge registers the result
    assign done = running && (cnt == 4'd0);

    // Load operands and counter on start, count down, register the result at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= 4'd0;
            op_q    <= OP_ADD;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            result  <= 16'h0000;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= 4'(LATENCY - 1);
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
        end else if (running) begin
            if (cnt == 4'd0) begin
                running <= 1'b0;
                result  <= (op_q == OP_SUB) ? (a_q - b_q) : (a_q + b_q);
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: rtl/add_reservation_station.sv
// Single-entry add/sub reservation station: issue, CDB operand snoop, execute, hold result for the arbiter.
// Latency: Done LATENCY edges after the edge on which the last operand becomes available.
// Backpressure: Issue ignored while Busy; Done/Q held until CDB_confirm is sampled in WRITE.
module add_reservation_station
    import tomasulo_defs::*;
#(
    parameter logic [2:0] TAG     = 3'd1,
    parameter int         LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Issue,
    input  logic        Op,
    input  logic [15:0] Vj,
    input  logic [15:0] Vk,
    input  logic [2:0]  Qj,
    input  logic [2:0]  Qk,
    input  logic        CDB_valid,
    input  logic [2:0]  Qi_CDB,
    input  logic [15:0] Qi_CDB_data,
    input  logic        CDB_confirm,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Q
);

    if (LATENCY < 1 || LATENCY > 15 || TAG == FREE_REGISTER) begin : g_bad_param
        $error("add_reservation_station: illegal LATENCY or TAG");
    end

    rs_state_t   state;
    logic        op_q;
    logic [15:0] vj_q, vk_q, vj_n, vk_n;
    logic [2:0]  qj_q, qk_q, qj_n, qk_n;
    logic        ops_ready;
    logic        exec_start;
    logic        exec_done;

    // Operand values/tags after this cycle's CDB snoop; in IDLE the snoop applies to the incoming issue
    always_comb begin
        vj_n = vj_q;
        vk_n = vk_q;
        qj_n = qj_q;
        qk_n = qk_q;
        if (state == ST_IDLE) begin
            vj_n = Vj;
            vk_n = Vk;
            qj_n = Qj;
            qk_n = Qk;
        end
        if (CDB_valid && (qj_n != FREE_REGISTER) && (Qi_CDB == qj_n)) begin
            vj_n = Qi_CDB_data;
            qj_n = FREE_REGISTER;
        end
        if (CDB_valid && (qk_n != FREE_REGISTER) && (Qi_CDB == qk_n)) begin
            vk_n = Qi_CDB_data;
            qk_n = FREE_REGISTER;
        end
    end

    assign ops_ready  = (qj_n == FREE_REGISTER) && (qk_n == FREE_REGISTER);
    assign exec_start = ops_ready &&
                        (((state == ST_IDLE) && Issue) || (state == ST_WAIT_OPS));

    add_sub_exec #(
        .LATENCY (LATENCY)
    ) u_exec (
        .clk    (Clock),
        .reset  (Reset),
        .start  (exec_start),
        .op     ((state == ST_IDLE) ? Op : op_q),
        .a      (vj_n),
        .b      (vk_n),
        .done   (exec_done),
        .result (Q)
    );

    // Station FSM with operand latches and registered Busy/Done
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            op_q  <= OP_ADD;
            vj_q  <= 16'h0000;
            vk_q  <= 16'h0000;
            qj_q  <= FREE_REGISTER;
            qk_q  <= FREE_REGISTER;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Issue) begin
                        op_q  <= Op;
                        vj_q  <= vj_n;
                        vk_q  <= vk_n;
                        qj_q  <= qj_n;
                        qk_q  <= qk_n;
                        Busy  <= 1'b1;
                        state <= ops_ready ? ST_EXEC : ST_WAIT_OPS;
                    end
                end
                ST_WAIT_OPS: begin
                    vj_q <= vj_n;
                    vk_q <= vk_n;
                    qj_q <= qj_n;
                    qk_q <= qk_n;
                    if (ops_ready) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        Done  <= 1'b1;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (CDB_confirm) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/add_reservation_station.md
# add_reservation_station

Single-entry reservation station plus add/sub functional unit for the Tomasulo datapath. It accepts an issued ADD/SUB with operand values or producer tags, snoops the CDB for missing operands, and executes over a fixed latency. It then presents `Done`/`Q` to the CDB arbiter and holds them until the arbiter's confirm. Two instances (TAG=1, TAG=2) drive the ADD1/ADD2 arbiter inputs.

## Interface
- `TAG`, default 3'd1: own station tag (1=ADD1, 2=ADD2); 0 is reserved for "value ready".
- `LATENCY`, default 2: execute cycles, legal 1..15.

Ports:
- `Clock` in 1: single clock, posedge.
- `Reset` in 1: synchronous, active-high.
- `Issue` in 1: issue request, honoured only when `Busy`=0.
- `Op` in 1: 0=ADD, 1=SUB (Vj−Vk).
- `Vj`, `Vk` in 16: operand values, valid when the matching Q tag is 0.
- `Qj`, `Qk` in 3: producer tags, 0 = value already in V.
- `CDB_valid` in 1: one-cycle strobe, new broadcast on `Qi_CDB`/`Qi_CDB_data`; the OR of the arbiter's four confirm outputs.
- `Qi_CDB` in 3: broadcast tag.
- `Qi_CDB_data` in 16: broadcast data.
- `CDB_confirm` in 1: arbiter grant for this station.
- `Busy` out 1: entry occupied.
- `Done` out 1: result valid, waiting for grant.
- `Q` out 16: result.

## Operation
- States: IDLE, WAIT_OPS, EXEC, WRITE.
- IDLE: when `Issue`=1, latch Op, Vj/Vk, Qj/Qk, and set `Busy`.
  - If both resolved tags are 0, go to EXEC; otherwise go to WAIT_OPS.
- Issue-time bypass: if `CDB_valid`=1 and `Qi_CDB` equals a nonzero incoming Qj/Qk in the issue cycle, latch `Qi_CDB_data` as that V and clear that tag.
- WAIT_OPS: on `CDB_valid`, each held tag equal to `Qi_CDB` captures the data and clears.
  - Qj and Qk may clear in the same cycle.
  - Go to EXEC on the edge where both tags are 0.
- EXEC: load the counter with LATENCY−1 on entry and decrement each cycle.
  - At 0, compute Vj+Vk or Vj−Vk modulo 2^16 (carry/borrow discarded), register it into `Q`, set `Done`, and go to WRITE.
- WRITE: hold `Done`=1 and `Q` stable until `CDB_confirm`=1 is sampled.
  - On that edge, go to IDLE and clear `Busy` and `Done`.
- Ignored inputs:
  - `Issue` while `Busy`=1; the issuer must not drop the instruction, and this is a checked protocol violation.
  - `CDB_confirm` outside WRITE.
  - `CDB_valid` with `Qi_CDB`=0, or with a tag not held.
- A new issue is accepted in the cycle after the confirm edge, not the same edge.

## Timing
- Reset values: `Busy`=0, `Done`=0, `Q`=16'h0000, state IDLE, tags 0, counter 0.
- Reset mid-operation aborts the entry with no output pulse.
- All state updates on posedge `Clock`.
- `CDB_valid`/`Qi_CDB`/`CDB_confirm` change on the arbiter's negedge and are sampled at the following posedge.
- Ready-operand issue at edge N:
  - `Busy`=1 after edge N.
  - `Done`=1 and `Q` valid after edge N+LATENCY.
- Broadcast resolving the last operand sampled at edge M: `Done` after edge M+LATENCY.
- Grant: the arbiter sees `Done` at the next negedge, and `CDB_confirm` is high over the following posedge.
  - `Done`/`Busy` fall at that posedge, so the minimum WRITE residency is 1 cycle.
  - With ADD1 priority a grant may be delayed indefinitely; `Q` stays stable the whole time.

## Structure
- Shared header/package `tomasulo_defs`:
  - station tags: FREE_REGISTER=0, RES_STATION_ADD1=1, ADD2=2, LOAD1=3, LOAD2=4;
  - OP_ADD/OP_SUB;
  - the 2-bit state encodings.
- One sub-module `add_sub_exec`: latency counter plus registered 16-bit add/sub, with start/op/a/b in and done/result out.
- The station FSM, operand latches and CDB snoop stay in the top module.

## Test plan
- Reset, then issue ADD Vj=5, Vk=7, Qj=Qk=0 at edge 0, LATENCY=2 -> `Busy` from edge 0; `Done`=1, `Q`=12 after edge 2; held until confirm; `Busy`=0 the edge after confirm.
- SUB with Qj=3, Vk=1; later CDB_valid with Qi_CDB=3, data=16'h0000 -> `Q`=16'hFFFF (wraps) LATENCY cycles after capture.
- Qj=Qk=4 and one broadcast tag 4, data=16'h8000 -> both captured; ADD gives `Q`=16'h0000 (carry dropped).
- Issue with Qj=1 in the same cycle as CDB_valid, Qi_CDB=1, data=9; Vk=1 -> bypass, direct to EXEC, `Q`=10; a non-matching broadcast (tag 2) leaves the tag pending.
- Withhold `CDB_confirm` for 5 cycles and assert `Issue` meanwhile -> `Done`/`Q` stable, issue ignored, latched operands unchanged.
- Assert `Reset` during EXEC and during WRITE -> all outputs return to 0 next edge; a later `CDB_confirm` is ignored.
